// File: rtl/ec_scalar_mult_ladder_if.sv
// ec_scalar_mult_ladder_if
//   Port bundle for the scalar-multiplier ladder: operand input handshake,
//   result output handshake, busy status and the req/done port group to the
//   shared point-add unit.
//   master : control layer / point-add side (drives operands, out_ready,
//            add results and add_done).
//   slave  : the ladder itself.
interface ec_scalar_mult_ladder_if #(
  parameter int DATA_WIDTH = 192,
  parameter int K_WIDTH    = 192
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] px;
  logic [DATA_WIDTH-1:0] py;
  logic [K_WIDTH-1:0]    k;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] rx;
  logic [DATA_WIDTH-1:0] ry;
  logic                  r_inf;
  logic                  busy;
  logic                  add_req;
  logic [DATA_WIDTH-1:0] add_px;
  logic [DATA_WIDTH-1:0] add_py;
  logic [DATA_WIDTH-1:0] add_qx;
  logic [DATA_WIDTH-1:0] add_qy;
  logic [DATA_WIDTH-1:0] add_rx;
  logic [DATA_WIDTH-1:0] add_ry;
  logic                  add_rinf;
  logic                  add_done;

  modport master (
    output in_valid, px, py, k, out_ready, add_rx, add_ry, add_rinf, add_done,
    input  in_ready, out_valid, rx, ry, r_inf, busy,
           add_req, add_px, add_py, add_qx, add_qy
  );

  modport slave (
    input  in_valid, px, py, k, out_ready, add_rx, add_ry, add_rinf, add_done,
    output in_ready, out_valid, rx, ry, r_inf, busy,
           add_req, add_px, add_py, add_qx, add_qy
  );
endinterface

// File: rtl/ec_scalar_mult_ladder.sv
// ec_scalar_mult_ladder
//   Elliptic-curve scalar multiplier R = k*P using MSB-first double-and-add.
//   Point add/double is delegated to an external point-add unit (doubling is
//   a request with P == Q). The point at infinity is tracked explicitly.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : ec_scalar_mult_ladder_if.slave
//            in_valid/in_ready + px/py/k      operand handshake
//            out_valid/out_ready + rx/ry/r_inf result handshake
//            busy                              accept .. output handshake
//            add_req/add_p*/add_q*             request to point-add unit
//            add_done/add_rx/add_ry/add_rinf   point-add completion
// Build option:
//   EC_LADDER_CONST_TIME_EN - every scalar bit issues one DBL and one ADD
//   request; dummy operations use (P, P) and their results are discarded.
module ec_scalar_mult_ladder #(
  parameter int DATA_WIDTH = 192,
  parameter int K_WIDTH    = 192,
  parameter int IDX_W      = $clog2(K_WIDTH)
) (
  input logic                    clk,
  input logic                    rst_n,
  ec_scalar_mult_ladder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_BIT, S_DBL_REQ, S_DBL_WAIT, S_ADD_REQ, S_ADD_WAIT, S_NEXT, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] px_q, px_d, py_q, py_d;
  logic [K_WIDTH-1:0]    k_q, k_d;
  logic [DATA_WIDTH-1:0] accx_q, accx_d, accy_q, accy_d;
  logic                  acc_inf_q, acc_inf_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, ry_q, ry_d;
  logic                  r_inf_q, r_inf_d;
  logic [DATA_WIDTH-1:0] opx_q, opx_d, opy_q, opy_d;
  logic [DATA_WIDTH-1:0] oqx_q, oqx_d, oqy_q, oqy_d;
`ifdef EC_LADDER_CONST_TIME_EN
  logic                  dummy_q, dummy_d;
`endif
  logic                  k_bit;

  assign k_bit = k_q[idx_q];

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    k_d         = k_q;
    accx_d      = accx_q;
    accy_d      = accy_q;
    acc_inf_d   = acc_inf_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    rx_d        = rx_q;
    ry_d        = ry_q;
    r_inf_d     = r_inf_q;
    opx_d       = opx_q;
    opy_d       = opy_q;
    oqx_d       = oqx_q;
    oqy_d       = oqy_q;
`ifdef EC_LADDER_CONST_TIME_EN
    dummy_d     = dummy_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          px_d      = bus.px;
          py_d      = bus.py;
          k_d       = bus.k;
          idx_d     = IDX_W'(K_WIDTH - 1);
          acc_inf_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_BIT;
        end
      end

      S_BIT: begin
`ifdef EC_LADDER_CONST_TIME_EN
        // Doubling infinity is replaced by a discarded (P, P) request.
        if (acc_inf_q) begin
          {opx_d, opy_d, oqx_d, oqy_d} = {px_q, py_q, px_q, py_q};
          dummy_d = 1'b1;
        end else begin
          {opx_d, opy_d, oqx_d, oqy_d} = {accx_q, accy_q, accx_q, accy_q};
          dummy_d = 1'b0;
        end
        state_d = S_DBL_REQ;
`else
        if (acc_inf_q) begin
          if (k_bit) begin
            accx_d    = px_q;
            accy_d    = py_q;
            acc_inf_d = 1'b0;
          end
          state_d = S_NEXT;
        end else begin
          {opx_d, opy_d, oqx_d, oqy_d} = {accx_q, accy_q, accx_q, accy_q};
          state_d = S_DBL_REQ;
        end
`endif
      end

      S_DBL_REQ: state_d = S_DBL_WAIT;

      S_DBL_WAIT: begin
        if (bus.add_done) begin
`ifdef EC_LADDER_CONST_TIME_EN
          if (!dummy_q) begin
            accx_d    = bus.add_rx;
            accy_d    = bus.add_ry;
            acc_inf_d = bus.add_rinf;
          end
          // ADD operands use the freshly doubled accumulator (acc_*_d).
          if (acc_inf_d || !k_bit) begin
            {opx_d, opy_d, oqx_d, oqy_d} = {px_q, py_q, px_q, py_q};
            dummy_d = 1'b1;
          end else begin
            {opx_d, opy_d, oqx_d, oqy_d} = {px_q, py_q, accx_d, accy_d};
            dummy_d = 1'b0;
          end
          state_d = S_ADD_REQ;
`else
          accx_d    = bus.add_rx;
          accy_d    = bus.add_ry;
          acc_inf_d = bus.add_rinf;
          if (k_bit) begin
            {opx_d, opy_d, oqx_d, oqy_d} = {px_q, py_q, accx_d, accy_d};
            state_d = S_ADD_REQ;
          end else begin
            state_d = S_NEXT;
          end
`endif
        end
      end

      S_ADD_REQ: state_d = S_ADD_WAIT;

      S_ADD_WAIT: begin
        if (bus.add_done) begin
`ifdef EC_LADDER_CONST_TIME_EN
          if (!dummy_q) begin
            accx_d    = bus.add_rx;
            accy_d    = bus.add_ry;
            acc_inf_d = bus.add_rinf;
          end else if (acc_inf_q && k_bit) begin
            accx_d    = px_q;
            accy_d    = py_q;
            acc_inf_d = 1'b0;
          end
`else
          accx_d    = bus.add_rx;
          accy_d    = bus.add_ry;
          acc_inf_d = bus.add_rinf;
`endif
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = S_BIT;
        end
      end

      S_DONE: begin
        if (!out_valid_q) begin
          rx_d        = acc_inf_q ? '0 : accx_q;
          ry_d        = acc_inf_q ? '0 : accy_q;
          r_inf_d     = acc_inf_q;
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered ready: a slot freed by the output handshake is offered
    // from the next cycle on.
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      px_q        <= '0;
      py_q        <= '0;
      k_q         <= '0;
      accx_q      <= '0;
      accy_q      <= '0;
      acc_inf_q   <= 1'b1;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rx_q        <= '0;
      ry_q        <= '0;
      r_inf_q     <= 1'b0;
      opx_q       <= '0;
      opy_q       <= '0;
      oqx_q       <= '0;
      oqy_q       <= '0;
`ifdef EC_LADDER_CONST_TIME_EN
      dummy_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      k_q         <= k_d;
      accx_q      <= accx_d;
      accy_q      <= accy_d;
      acc_inf_q   <= acc_inf_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      r_inf_q     <= r_inf_d;
      opx_q       <= opx_d;
      opy_q       <= opy_d;
      oqx_q       <= oqx_d;
      oqy_q       <= oqy_d;
`ifdef EC_LADDER_CONST_TIME_EN
      dummy_q     <= dummy_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.rx        = rx_q;
  assign bus.ry        = ry_q;
  assign bus.r_inf     = r_inf_q;
  assign bus.busy      = busy_q;
  assign bus.add_req   = (state_q == S_DBL_REQ) || (state_q == S_ADD_REQ);
  assign bus.add_px    = opx_q;
  assign bus.add_py    = opy_q;
  assign bus.add_qx    = oqx_q;
  assign bus.add_qy    = oqy_q;

endmodule

// File: tb/tb_ec_scalar_mult_ladder.sv
// tb_ec_scalar_mult_ladder
//   Directed bench for ec_scalar_mult_ladder with K_WIDTH=8, DATA_WIDTH=16.
//   The point-add model works in the additive group Z(2^16)^2, so n*P is
//   simply (n*px, n*py); expected results are hand-computed constants.
module tb_ec_scalar_mult_ladder;
  localparam int DW  = 16;
  localparam int KW  = 8;
  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ec_scalar_mult_ladder_if #(.DATA_WIDTH(DW), .K_WIDTH(KW)) bus ();

  ec_scalar_mult_ladder #(.DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- point-add model ----------------
  int          n_req     = 0;
  int          n_dbl     = 0;
  int          spur_cnt  = 0;
  int          spur_seen = 0;
  int          m_cnt     = 0;
  bit          force_inf = 1'b0;
  logic [DW-1:0] m_rx, m_ry, la_px, la_qx, la_qy;
  logic          m_rinf;

  initial begin
    bus.add_done = 1'b0;
    bus.add_rx   = '0;
    bus.add_ry   = '0;
    bus.add_rinf = 1'b0;
    la_px = '0; la_qx = '0; la_qy = '0;
    m_rx = '0; m_ry = '0; m_rinf = 1'b0;
    forever begin
      @(negedge clk);
      bus.add_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.add_rx   = m_rx;
          bus.add_ry   = m_ry;
          bus.add_rinf = m_rinf;
          bus.add_done = 1'b1;
        end
      end else if (bus.add_req) begin
        n_req++;
        if (bus.add_px == bus.add_qx && bus.add_py == bus.add_qy) begin
          n_dbl++;
          m_rx   = bus.add_px << 1;
          m_ry   = bus.add_py << 1;
          m_rinf = 1'b0;
        end else begin
          la_px  = bus.add_px;
          la_qx  = bus.add_qx;
          la_qy  = bus.add_qy;
          m_rx   = bus.add_px + bus.add_qx;
          m_ry   = bus.add_py + bus.add_qy;
          m_rinf = force_inf;
        end
        m_cnt = LAT;
      end
      if (spur_cnt != spur_seen) begin
        spur_seen    = spur_cnt;
        bus.add_rx   = 16'hDEAD;
        bus.add_ry   = 16'hBEEF;
        bus.add_rinf = 1'b1;
        bus.add_done = 1'b1;
      end
    end
  end

  // ---------------- one full operation ----------------
  task automatic run_op(input logic [7:0] kk, input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input int hold, output int cyc, output int reqs, output int dbls,
                        output logic [DW-1:0] ox, output logic [DW-1:0] oy, output logic oinf);
    int r0 = n_req;
    int d0 = n_dbl;
    int guard = 0;
    int stable = 0;
    cyc = 0; reqs = 0; dbls = 0; ox = '0; oy = '0; oinf = 1'b0;
    bus.px = x; bus.py = y; bus.k = kk; bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) begin
      check_eq("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_eq("busy_set", 32'(bus.busy), 1);
    while (!bus.out_valid && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.out_valid) begin
      check_eq("result_timeout", 0, 1);
      return;
    end
    ox = bus.rx; oy = bus.ry; oinf = bus.r_inf;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bus.rx == ox && bus.ry == oy && bus.r_inf == oinf && bus.out_valid && !bus.in_ready)
        stable++;
    end
    if (hold > 0) check_eq("hold_stable", 32'(stable), 32'(hold));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq("out_valid_drop", 32'(bus.out_valid), 0);
    check_eq("busy_drop", 32'(bus.busy), 0);
    reqs = n_req - r0;
    dbls = n_dbl - d0;
  endtask

  // ---------------- stimulus ----------------
  int            cyc, reqs, dbls, g, r0;
  logic [DW-1:0] ox, oy;
  logic          oinf;

  initial begin
    bus.in_valid = 1'b0; bus.px = '0; bus.py = '0; bus.k = '0; bus.out_ready = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_add_req", 32'(bus.add_req), 0);
    check_eq("rst_rx", 32'(bus.rx), 0);
    check_eq("rst_r_inf", 32'(bus.r_inf), 0);
    check_eq("rst_add_px", 32'(bus.add_px), 0);
    check_eq("rst_add_qy", 32'(bus.add_qy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_in_ready", 32'(bus.in_ready), 1);

`ifdef EC_LADDER_CONST_TIME_EN
    // per bit: BIT + DBL_REQ + 3 wait + ADD_REQ + 3 wait + NEXT = 10; +1 for DONE
    run_op(8'h05, 16'd11, 16'd22, 0, cyc, reqs, dbls, ox, oy, oinf);
    check_eq("ct05_reqs", 32'(reqs), 16);
    check_eq("ct05_cycles", 32'(cyc), 81);
    check_eq("ct05_rx", 32'(ox), 55);
    check_eq("ct05_ry", 32'(oy), 110);
    check_eq("ct05_inf", 32'(oinf), 0);
    run_op(8'hFF, 16'd11, 16'd22, 0, cyc, reqs, dbls, ox, oy, oinf);
    check_eq("ctFF_reqs", 32'(reqs), 16);
    check_eq("ctFF_cycles", 32'(cyc), 81);
    check_eq("ctFF_rx", 32'(ox), 2805);
    check_eq("ctFF_ry", 32'(oy), 5610);
    check_eq("ctFF_inf", 32'(oinf), 0);
`else
    run_op(8'h05, 16'd11, 16'd22, 0, cyc, reqs, dbls, ox, oy, oinf);
    check_eq("k05_reqs", 32'(reqs), 3);
    check_eq("k05_dbls", 32'(dbls), 2);
    check_eq("k05_add_px", 32'(la_px), 11);
    check_eq("k05_add_qx", 32'(la_qx), 44);
    check_eq("k05_add_qy", 32'(la_qy), 88);
    check_eq("k05_rx", 32'(ox), 55);
    check_eq("k05_ry", 32'(oy), 110);
    check_eq("k05_inf", 32'(oinf), 0);
    check_eq("k05_cycles", 32'(cyc), 29);

    run_op(8'h00, 16'd11, 16'd22, 0, cyc, reqs, dbls, ox, oy, oinf);
    check_eq("k00_reqs", 32'(reqs), 0);
    check_eq("k00_cycles", 32'(cyc), 17);
    check_eq("k00_inf", 32'(oinf), 1);
    check_eq("k00_rx", 32'(ox), 0);
    check_eq("k00_ry", 32'(oy), 0);

    run_op(8'h80, 16'd11, 16'd22, 0, cyc, reqs, dbls, ox, oy, oinf);
    check_eq("k80_dbls", 32'(dbls), 7);
    check_eq("k80_adds", 32'(reqs - dbls), 0);
    check_eq("k80_rx", 32'(ox), 1408);
    check_eq("k80_ry", 32'(oy), 2816);

    run_op(8'h01, 16'd11, 16'd22, 0, cyc, reqs, dbls, ox, oy, oinf);
    check_eq("k01_reqs", 32'(reqs), 0);
    check_eq("k01_rx", 32'(ox), 11);
    check_eq("k01_ry", 32'(oy), 22);
    check_eq("k01_inf", 32'(oinf), 0);

    force_inf = 1'b1;
    run_op(8'h03, 16'd11, 16'd22, 0, cyc, reqs, dbls, ox, oy, oinf);
    force_inf = 1'b0;
    check_eq("kinf_reqs", 32'(reqs), 2);
    check_eq("kinf_inf", 32'(oinf), 1);
    check_eq("kinf_rx", 32'(ox), 0);
    check_eq("kinf_ry", 32'(oy), 0);

    run_op(8'h05, 16'd7, 16'd9, 10, cyc, reqs, dbls, ox, oy, oinf);
    check_eq("hold_rx", 32'(ox), 35);
    check_eq("hold_ry", 32'(oy), 45);

    spur_cnt++;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("spur_out_valid", 32'(bus.out_valid), 0);
    check_eq("spur_busy", 32'(bus.busy), 0);
    check_eq("spur_in_ready", 32'(bus.in_ready), 1);
    run_op(8'h02, 16'd3, 16'd5, 0, cyc, reqs, dbls, ox, oy, oinf);
    check_eq("k02_reqs", 32'(reqs), 1);
    check_eq("k02_rx", 32'(ox), 6);
    check_eq("k02_ry", 32'(oy), 10);
`endif

    // reset asserted while the ladder waits on its first doubling
    r0 = n_req;
    bus.px = 16'd11; bus.py = 16'd22; bus.k = 8'h05; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    g = 0;
    while (n_req == r0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("mid_req_seen", 32'(n_req - r0), 1);
    check_eq("mid_add_px_before", 32'(bus.add_px), 11);
    rst_n = 1'b0;
    #1;
    check_eq("mid_add_req", 32'(bus.add_req), 0);
    check_eq("mid_busy", 32'(bus.busy), 0);
    check_eq("mid_out_valid", 32'(bus.out_valid), 0);
    check_eq("mid_in_ready", 32'(bus.in_ready), 0);
    check_eq("mid_add_px", 32'(bus.add_px), 0);
    check_eq("mid_add_qx", 32'(bus.add_qx), 0);
    check_eq("mid_rx", 32'(bus.rx), 0);
    check_eq("mid_r_inf", 32'(bus.r_inf), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check_eq("post_rst_in_ready", 32'(bus.in_ready), 1);
    check_eq("post_rst_out_valid", 32'(bus.out_valid), 0);
    run_op(8'h05, 16'd11, 16'd22, 0, cyc, reqs, dbls, ox, oy, oinf);
    check_eq("post_rst_rx", 32'(ox), 55);
    check_eq("post_rst_ry", 32'(oy), 110);
    check_eq("post_rst_inf", 32'(oinf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
